// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - front-panel key/mode controller for the stopwatch/timer display
// Debounces start/stop and clear, runs the CLEAR/IDLE/RUN/PAUSE/DONE machine, makes the 1 Hz tick and alarm blink.
module stopwatch_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_startstop_n,
  input  logic       key_clear_n,
  input  logic       sw_timer,
  input  logic [1:0] sw_preset,
  input  logic       done_time,
  output logic       one_second,
  output logic       start_clk,
  output logic       timer,
  output logic       fifteen,
  output logic       thirty,
  output logic       fortyfive,
  output logic       disp_reset,
  output logic       alarm_led
);

  localparam int TW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(CLK_HZ - 1);
  localparam logic [TW-1:0] BLINK_MAX = TW'(CLK_HZ / 4 - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    raw_pressed;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    level_q, level_d, level_prev_q;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic          press_start, press_clear;
  logic          timer_q, timer_d;
  logic [1:0]    preset_q, preset_d;
  logic          sw_changed;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          alarm_q, alarm_d;

  // Index 0 is start/stop, index 1 is clear.
  assign raw_pressed = {~key_clear_n, ~key_startstop_n};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      level_d[k]  = level_q[k];
      db_cnt_d[k] = '0;
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_MAX) level_d[k] = sync2_q[k];
        else                       db_cnt_d[k] = db_cnt_q[k] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q      <= raw_pressed;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= db_cnt_d[k];
    end
  end

  assign press_start = level_q[0] & ~level_prev_q[0];
  assign press_clear = level_q[1] & ~level_prev_q[1];
  assign sw_changed  = (sw_timer != timer_q) || (sw_preset != preset_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: state_d = S_IDLE;
      S_IDLE: begin
        if (press_clear)      state_d = S_CLEAR;
        else if (press_start) state_d = S_RUN;
        else if (sw_changed)  state_d = S_CLEAR;
      end
      S_RUN: begin
        if (press_clear)                state_d = S_CLEAR;
        else if (timer_q && done_time)  state_d = S_DONE;
        else if (press_start)           state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (press_clear)      state_d = S_CLEAR;
        else if (press_start) state_d = S_RUN;
      end
      S_DONE: begin
        if (press_clear) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Latches load on entry to CLEAR so the strobes are valid alongside disp_reset.
  always_comb begin
    timer_d  = timer_q;
    preset_d = preset_q;
    if (state_d == S_CLEAR && state_q != S_CLEAR) begin
      timer_d  = sw_timer;
      preset_d = sw_preset;
    end
  end

  always_comb begin
    tick_cnt_d = '0;
    case (state_q)
      S_RUN: begin
        if (state_d == S_DONE)        tick_cnt_d = '0;
        else if (tick_cnt_q == TICK_MAX) tick_cnt_d = '0;
        else                          tick_cnt_d = tick_cnt_q + TW'(1);
      end
      S_PAUSE: tick_cnt_d = tick_cnt_q;
      S_DONE: begin
        if (tick_cnt_q >= BLINK_MAX) tick_cnt_d = '0;
        else                         tick_cnt_d = tick_cnt_q + TW'(1);
      end
      default: tick_cnt_d = '0;
    endcase
  end

  always_comb begin
    alarm_d = 1'b0;
    if (state_q == S_DONE && state_d == S_DONE)
      alarm_d = alarm_q ^ (tick_cnt_q >= BLINK_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q    <= 1'b0;
      preset_q   <= 2'b00;
      tick_cnt_q <= '0;
      alarm_q    <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      preset_q   <= preset_d;
      tick_cnt_q <= tick_cnt_d;
      alarm_q    <= alarm_d;
    end
  end

  always_comb begin
    disp_reset = (state_q == S_CLEAR);
    start_clk  = (state_q == S_RUN);
    one_second = (state_q == S_RUN) && (tick_cnt_q == TICK_MAX);
    timer      = timer_q;
    fifteen    = (preset_q == 2'b01);
    thirty     = (preset_q == 2'b10);
    fortyfive  = (preset_q == 2'b11);
    alarm_led  = alarm_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench for stopwatch_ctrl
// Output vector order: disp_reset, start_clk, one_second, timer, fifteen, thirty, fortyfive, alarm_led.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_startstop_n;
  logic       key_clear_n;
  logic       sw_timer;
  logic [1:0] sw_preset;
  logic       done_time;
  logic       one_second, start_clk, timer, fifteen, thirty, fortyfive, disp_reset, alarm_led;
  logic [7:0] outs;

  int n_vec = 0;
  int n_bad = 0;

  stopwatch_ctrl #(.CLK_HZ(8), .DEBOUNCE_CYC(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .key_startstop_n (key_startstop_n),
    .key_clear_n     (key_clear_n),
    .sw_timer        (sw_timer),
    .sw_preset       (sw_preset),
    .done_time       (done_time),
    .one_second      (one_second),
    .start_clk       (start_clk),
    .timer           (timer),
    .fifteen         (fifteen),
    .thirty          (thirty),
    .fortyfive       (fortyfive),
    .disp_reset      (disp_reset),
    .alarm_led       (alarm_led)
  );

  always #5 clk = ~clk;

  assign outs = {disp_reset, start_clk, one_second, timer, fifteen, thirty, fortyfive, alarm_led};

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n_tick;
    int first;
    int bad;
    int n_pause;

    reset = 1'b0;
    key_startstop_n = 1'b1;
    key_clear_n = 1'b1;
    sw_timer = 1'b0;
    sw_preset = 2'b00;
    done_time = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_outs", outs, 8'h80);
    reset = 1'b1;
    #1;
    check_vec("rst_release_clear", outs, 8'h80);
    tick();
    check_vec("rst_idle", outs, 8'h00);

    // stopwatch: press latency and tick cadence
    key_startstop_n = 1'b0;
    ticks(5);
    check_vec("start_lat5", start_clk, 1'b0);
    tick();
    check_vec("start_lat6", start_clk, 1'b1);
    key_startstop_n = 1'b1;
    n_tick = 0; first = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) tick();
      if (one_second) begin
        n_tick++;
        if (first == 0) first = i;
        if (!start_clk) bad++;
      end
    end
    check_vec("ticks_in_40", n_tick, 5);
    check_vec("first_tick_cycle", first, 8);
    check_vec("tick_outside_run", bad, 0);

    // pause with counter at 5
    tick();
    key_startstop_n = 1'b0;
    n_tick = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (one_second) n_tick++;
    end
    check_vec("pre_pause_notick", n_tick, 0);
    check_vec("pre_pause_run", start_clk, 1'b1);
    tick();
    check_vec("paused", outs, 8'h00);
    key_startstop_n = 1'b1;
    n_pause = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      if (one_second || start_clk) n_pause++;
      if (i == 8) key_startstop_n = 1'b0;
      if (i == 10) key_startstop_n = 1'b1;
    end
    check_vec("pause_quiet", n_pause, 0);
    check_vec("bounce_no_event", outs, 8'h00);
    key_startstop_n = 1'b0;
    ticks(6);
    check_vec("resume_run", outs, 8'h40);
    tick();
    check_vec("resume_tick", outs, 8'h60);
    key_startstop_n = 1'b1;

    key_clear_n = 1'b0;
    ticks(6);
    check_vec("clear_from_run", outs, 8'h80);
    tick();
    check_vec("clear_idle", outs, 8'h00);
    key_clear_n = 1'b1;
    ticks(7);

    // timer preset 30 s
    sw_timer = 1'b1;
    sw_preset = 2'b10;
    tick();
    check_vec("preset_load", outs, 8'h94);
    tick();
    check_vec("preset_idle", outs, 8'h14);
    key_startstop_n = 1'b0;
    ticks(6);
    check_vec("timer_run", outs, 8'h54);
    key_startstop_n = 1'b1;
    sw_timer = 1'b0;
    sw_preset = 2'b01;
    ticks(3);
    check_vec("sw_in_run_ignored", outs, 8'h54);
    sw_timer = 1'b1;
    sw_preset = 2'b10;

    // countdown done and alarm blink
    done_time = 1'b1;
    tick();
    check_vec("done_enter", outs, 8'h14);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check_vec($sformatf("alarm_%0d", i), alarm_led, (i >> 1) & 1);
    end
    key_startstop_n = 1'b0;
    ticks(6);
    check_vec("done_start_ignored", outs & 8'hC0, 8'h00);
    key_startstop_n = 1'b1;
    ticks(6);
    key_clear_n = 1'b0;
    ticks(6);
    check_vec("done_clear", outs, 8'h94);
    done_time = 1'b0;
    tick();
    check_vec("done_clear_idle", outs, 8'h14);
    key_clear_n = 1'b1;
    ticks(6);

    // clear wins over start in the same cycle
    key_startstop_n = 1'b0;
    ticks(6);
    check_vec("prio_run", outs, 8'h54);
    key_startstop_n = 1'b1;
    ticks(8);
    key_startstop_n = 1'b0;
    key_clear_n = 1'b0;
    ticks(6);
    check_vec("prio_clear", outs, 8'h94);
    tick();
    check_vec("prio_idle", outs, 8'h14);
    key_startstop_n = 1'b1;
    key_clear_n = 1'b1;
    ticks(6);

    // asynchronous reset mid-count
    key_startstop_n = 1'b0;
    ticks(6);
    check_vec("rst_run", outs, 8'h54);
    key_startstop_n = 1'b1;
    ticks(3);
    reset = 1'b0;
    #1;
    check_vec("async_rst", outs, 8'h80);
    @(posedge clk);
    #1;
    check_vec("async_rst_hold", outs, 8'h80);
    reset = 1'b1;
    tick();
    check_vec("post_rst_idle", outs, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel controller that sits upstream of the stopwatch/timer display datapath. It debounces the start/stop and clear keys and latches the mode and preset switches. It runs the run/pause/done state machine and produces the 1 Hz tick, run-enable, preset strobes and synchronous display reset that the display consumes. It also consumes the display's `done_time` flag and drives a blinking alarm LED when a countdown expires.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per second; legal range ≥ 8.
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a key level; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `key_startstop_n`  in  1  raw start/stop push-button, active-low, asynchronous.
- `key_clear_n`  in  1  raw clear push-button, active-low, asynchronous.
- `sw_timer`  in  1  mode switch: 0 = count up (stopwatch), 1 = count down (timer).
- `sw_preset`  in  2  timer preset: 00 = none, 01 = 15 s, 10 = 30 s, 11 = 45 s.
- `done_time`  in  1  display countdown-expired flag; sticky until the display is reset.
- `one_second`  out  1  one-cycle tick, once per `CLK_HZ` cycles while running.
- `start_clk`  out  1  high while in RUN.
- `timer`  out  1  latched mode.
- `fifteen`, `thirty`, `fortyfive`  out  1 each  latched one-hot preset; all 0 for preset 00.
- `disp_reset`  out  1  active-high synchronous reset/preset-load pulse to the display.
- `alarm_led`  out  1  blinks at 2 Hz in DONE.

## Operation

- Key path, per key:
  - 2-FF synchronizer on the inverted raw input, giving pressed = 1.
  - Debounce counter: the accepted level changes only after the synchronized level has differed from it for `DEBOUNCE_CYC` consecutive cycles; any bounce restarts the count.
  - Press event = one-cycle pulse on the accepted level's 0→1 edge. Releases generate no event.
- States: CLEAR, IDLE, RUN, PAUSE, DONE. Asynchronous reset forces CLEAR.
- Transitions are evaluated on press events. When both keys fire in the same cycle, clear has priority.
  - CLEAR → IDLE unconditionally after 1 cycle.
  - IDLE: clear → CLEAR; start → RUN; `sw_timer` or `sw_preset` differs from the latched value → CLEAR, which reloads the latches.
  - RUN: clear → CLEAR; start → PAUSE; `timer`=1 and `done_time`=1 → DONE. A start press in the same cycle as done is ignored, so the block goes to DONE.
  - PAUSE: clear → CLEAR; start → RUN.
  - DONE: clear → CLEAR; start ignored.
- Latching: `timer` and the preset strobes load from the switches only in CLEAR. Switch changes in RUN, PAUSE or DONE have no effect.
- Outputs, all decoded from registers:
  - `disp_reset` = (state == CLEAR).
  - `start_clk` = (state == RUN).
  - `one_second` = (state == RUN) and (tick_cnt == `CLK_HZ`−1).
- Tick counter:
  - Width `$clog2(CLK_HZ)`.
  - In RUN it increments and wraps `CLK_HZ`−1 → 0.
  - It holds in PAUSE, so a partial second is preserved.
  - It clears to 0 in CLEAR and IDLE.
  - In DONE it is reused as the blink timer.
- Alarm: `alarm_led` toggles each time the counter wraps at `CLK_HZ`/4−1 in DONE. It is 0 in every other state.

## Timing

- Reset values: state CLEAR, `disp_reset`=1, `timer`=0, `fifteen`/`thirty`/`fortyfive`=0, `start_clk`=0, `one_second`=0, `alarm_led`=0, counters 0.
- After reset deasserts: `disp_reset` stays high for exactly 1 cycle, then the block is in IDLE.
- Key latency: a clean press reaches its state change after 2 (sync) + `DEBOUNCE_CYC` + 1 cycles.
- First tick: occurs `CLK_HZ` cycles after RUN is entered from IDLE. After a pause/resume it occurs after the remaining count.
- `one_second` and `start_clk` are always high in the same cycle; a tick never appears outside RUN.
- A start press in the same cycle as a tick: the tick is still issued, and PAUSE is entered next cycle.
- `done_time` is sampled every cycle; DONE is entered 1 cycle after it is seen high in RUN.
- Reset asserted mid-run clears all state immediately, with no tick or `disp_reset` glitch beyond the reset values.

## Test plan

- Reset: `CLK_HZ`=8, `DEBOUNCE_CYC`=3; release reset → `disp_reset` high 1 cycle, all other outputs 0, then IDLE.
- Stopwatch run: `sw_timer`=0, clean start press → `start_clk`=1 at 2+3+1 cycles; `one_second` pulses every 8 cycles, 5 pulses in 40 cycles.
- Pause/resume: pause at tick_cnt=5, wait 20 cycles with no ticks, resume → next tick after 2 cycles; second press before debounce expiry (bounce of 2 cycles) → no event.
- Timer preset: in IDLE, change `sw_preset` to 10 with `sw_timer`=1 → `disp_reset` 1 cycle with `thirty`=1, `timer`=1; changing the switch during RUN leaves outputs unchanged.
- Done/alarm: in RUN with `timer`=1, raise `done_time` → DONE next cycle, `start_clk`=0, `alarm_led` toggles every 2 cycles; start press ignored; clear → `alarm_led`=0, `disp_reset` pulse.
- Priority: start and clear events in the same cycle during RUN → CLEAR; async reset during RUN mid-count → outputs at reset values immediately.
